gol_board_state: RTL and testbench

Double-buffered, parametrised board store for the Game of Life engine, successor to the single-bank row register file. It holds the current generation in one bank while the update datapath writes the next generation into the other. On a qualified commit the banks swap in one cycle. Three combinational read ports deliver the row above, the current row and the row below for neighbour evaluation, and the block tracks generation count, stability and extinction.

---
 rtl/gol_pkg.sv | 58 +++++
 rtl/gol_bank.sv | 69 ++++++
 rtl/gol_board_state.sv | 162 ++++++++++++++++
 tb/tb_gol_board_state.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// Shared types, default sizes and neighbour-row index helpers for the
// Game of Life board store.
// Optional build macro: GOL_TORUS_EN (rows wrap top-to-bottom when defined,
// dead boundary rows otherwise).
package gol_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_ROWS  = 8;

    typedef logic [DEFAULT_WIDTH-1:0] row_t;

    // Neighbour lookup result: valid = 0 means "read as dead row".
    typedef struct packed {
        logic        valid;
        logic [31:0] idx;
    } nbr_t;

    // Row above the centre row (or none / wrapped, depending on build).
    function automatic nbr_t prev_row(input logic [31:0] ra, input logic [31:0] rows);
        nbr_t n;
        n.valid = 1'b0;
        n.idx   = '0;
        if (ra < rows) begin
            if (ra != 32'd0) begin
                n.valid = 1'b1;
                n.idx   = ra - 32'd1;
            end
`ifdef GOL_TORUS_EN
            else begin
                n.valid = 1'b1;
                n.idx   = rows - 32'd1;
            end
`endif
        end
        return n;
    endfunction

    // Row below the centre row (or none / wrapped, depending on build).
    function automatic nbr_t next_row(input logic [31:0] ra, input logic [31:0] rows);
        nbr_t n;
        n.valid = 1'b0;
        n.idx   = '0;
        if (ra < rows) begin
            if ((ra + 32'd1) < rows) begin
                n.valid = 1'b1;
                n.idx   = ra + 32'd1;
            end
`ifdef GOL_TORUS_EN
            else begin
                n.valid = 1'b1;
                n.idx   = 32'd0;
            end
`endif
        end
        return n;
    endfunction

endpackage

// File: rtl/gol_bank.sv
// One ROWS x WIDTH board bank: single write port, three combinational
// neighbour read ports, a compare port used to detect changed rows, and an
// all-zero detect. Out-of-range addresses are ignored on write and read 0.
// Boundary behaviour follows GOL_TORUS_EN through the gol_pkg helpers.
import gol_pkg::*;

module gol_bank #(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int ROWS    = DEFAULT_ROWS,
    parameter int REGBITS = $clog2(ROWS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [REGBITS-1:0] wa,
    input  logic [WIDTH-1:0]   wd,
    input  logic [REGBITS-1:0] ra,
    output logic [WIDTH-1:0]   rd_above,
    output logic [WIDTH-1:0]   rd_cur,
    output logic [WIDTH-1:0]   rd_below,
    input  logic [REGBITS-1:0] cmp_addr,
    input  logic [WIDTH-1:0]   cmp_data,
    output logic               cmp_ne,
    output logic               zero
);

    logic [WIDTH-1:0] r_mem [ROWS];
    nbr_t             w_above_n;
    nbr_t             w_below_n;
    logic [WIDTH-1:0] w_cmp_row;
    logic [WIDTH-1:0] w_any;

    // Row storage; writes to addresses beyond ROWS-1 match no row and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROWS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            for (int i = 0; i < ROWS; i++) begin
                if (32'(wa) == 32'(i)) begin
                    r_mem[i] <= wd;
                end
            end
        end
    end

    // Combinational read muxes, compare-row fetch and OR-reduction of all rows.
    always_comb begin
        w_above_n = prev_row(32'(ra), 32'(ROWS));
        w_below_n = next_row(32'(ra), 32'(ROWS));
        rd_above  = '0;
        rd_cur    = '0;
        rd_below  = '0;
        w_cmp_row = '0;
        w_any     = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (w_above_n.valid && (w_above_n.idx == 32'(i))) rd_above = r_mem[i];
            if (32'(ra) == 32'(i))                           rd_cur   = r_mem[i];
            if (w_below_n.valid && (w_below_n.idx == 32'(i))) rd_below = r_mem[i];
            if (32'(cmp_addr) == 32'(i))                     w_cmp_row = r_mem[i];
            w_any = w_any | r_mem[i];
        end
    end

    assign cmp_ne = (w_cmp_row != cmp_data);
    assign zero   = ~|w_any;

endmodule

// File: rtl/gol_board_state.sv
// Double-buffered Game of Life board store. The current bank serves the
// neighbour read ports and seed loads; the shadow bank collects the next
// generation. A qualified commit swaps the banks in one cycle and updates
// generation count and stability.
// Optional build macro: GOL_TORUS_EN (toroidal row wrap on rd_above/rd_below).
import gol_pkg::*;

module gol_board_state #(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int ROWS    = DEFAULT_ROWS,
    parameter int REGBITS = $clog2(ROWS),
    parameter int GENBITS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_en,
    input  logic [REGBITS-1:0] load_addr,
    input  logic [WIDTH-1:0]   load_data,
    input  logic               we,
    input  logic [REGBITS-1:0] wa,
    input  logic [WIDTH-1:0]   wd,
    input  logic               commit,
    input  logic [REGBITS-1:0] ra,
    output logic [WIDTH-1:0]   rd_above,
    output logic [WIDTH-1:0]   rd_cur,
    output logic [WIDTH-1:0]   rd_below,
    output logic               commit_ready,
    output logic               commit_ack,
    output logic [GENBITS-1:0] gen_count,
    output logic               stable,
    output logic               all_dead
);

    // r_bank_sel = 0: bank 0 is current, bank 1 is shadow; 1: the reverse.
    logic               r_bank_sel;
    logic [ROWS-1:0]    r_written;
    logic [ROWS-1:0]    r_diff;
    logic [GENBITS-1:0] r_gen;
    logic               r_stable;
    logic               r_ack;

    logic               w_b0_we, w_b1_we;
    logic [REGBITS-1:0] w_b0_wa, w_b1_wa;
    logic [WIDTH-1:0]   w_b0_wd, w_b1_wd;
    logic [WIDTH-1:0]   w_b0_above, w_b0_cur, w_b0_below;
    logic [WIDTH-1:0]   w_b1_above, w_b1_cur, w_b1_below;
    logic               w_b0_cmp_ne, w_b1_cmp_ne;
    logic               w_b0_zero, w_b1_zero;
    logic               w_cur_cmp_ne;
    logic [ROWS-1:0]    w_written_nx;
    logic [ROWS-1:0]    w_diff_nx;
    logic               w_take;

    // Seed loads go to the current bank, next-generation writes to the shadow.
    assign w_b0_we = r_bank_sel ? we        : load_en;
    assign w_b0_wa = r_bank_sel ? wa        : load_addr;
    assign w_b0_wd = r_bank_sel ? wd        : load_data;
    assign w_b1_we = r_bank_sel ? load_en   : we;
    assign w_b1_wa = r_bank_sel ? load_addr : wa;
    assign w_b1_wd = r_bank_sel ? load_data : wd;

    gol_bank #(
        .WIDTH   (WIDTH),
        .ROWS    (ROWS),
        .REGBITS (REGBITS)
    ) u_bank0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (w_b0_we),
        .wa       (w_b0_wa),
        .wd       (w_b0_wd),
        .ra       (ra),
        .rd_above (w_b0_above),
        .rd_cur   (w_b0_cur),
        .rd_below (w_b0_below),
        .cmp_addr (wa),
        .cmp_data (wd),
        .cmp_ne   (w_b0_cmp_ne),
        .zero     (w_b0_zero)
    );

    gol_bank #(
        .WIDTH   (WIDTH),
        .ROWS    (ROWS),
        .REGBITS (REGBITS)
    ) u_bank1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (w_b1_we),
        .wa       (w_b1_wa),
        .wd       (w_b1_wd),
        .ra       (ra),
        .rd_above (w_b1_above),
        .rd_cur   (w_b1_cur),
        .rd_below (w_b1_below),
        .cmp_addr (wa),
        .cmp_data (wd),
        .cmp_ne   (w_b1_cmp_ne),
        .zero     (w_b1_zero)
    );

    // Reads and change detection always come from the current bank.
    assign rd_above     = r_bank_sel ? w_b1_above  : w_b0_above;
    assign rd_cur       = r_bank_sel ? w_b1_cur    : w_b0_cur;
    assign rd_below     = r_bank_sel ? w_b1_below  : w_b0_below;
    assign all_dead     = r_bank_sel ? w_b1_zero   : w_b0_zero;
    assign w_cur_cmp_ne = r_bank_sel ? w_b1_cmp_ne : w_b0_cmp_ne;

    // Masks with this cycle's next-gen write merged in (rewrites replace the diff bit).
    always_comb begin
        w_written_nx = r_written;
        w_diff_nx    = r_diff;
        if (we) begin
            for (int i = 0; i < ROWS; i++) begin
                if (32'(wa) == 32'(i)) begin
                    w_written_nx[i] = 1'b1;
                    w_diff_nx[i]    = w_cur_cmp_ne;
                end
            end
        end
    end

    // Commit handshake: commit is a request, commit_ready says every row has
    // been written; the swap is taken when the request meets readiness (with
    // any same-cycle write counted) and no seed load is in progress.
    assign w_take       = commit && (&w_written_nx) && !load_en;
    assign commit_ready = &r_written;

    // Bank select, masks, generation counter, stability and the ack pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank_sel <= 1'b0;
            r_written  <= '0;
            r_diff     <= '0;
            r_gen      <= '0;
            r_stable   <= 1'b0;
            r_ack      <= 1'b0;
        end else if (load_en) begin
            r_written  <= '0;
            r_diff     <= '0;
            r_gen      <= '0;
            r_stable   <= 1'b0;
            r_ack      <= 1'b0;
        end else if (w_take) begin
            r_bank_sel <= ~r_bank_sel;
            r_written  <= '0;
            r_diff     <= '0;
            r_gen      <= r_gen + 1'b1;
            r_stable   <= ~|w_diff_nx;
            r_ack      <= 1'b1;
        end else begin
            r_written  <= w_written_nx;
            r_diff     <= w_diff_nx;
            r_ack      <= 1'b0;
        end
    end

    assign commit_ack = r_ack;
    assign gen_count  = r_gen;
    assign stable     = r_stable;

endmodule

// File: tb/tb_gol_board_state.sv
// Self-checking bench for gol_board_state: a default 8-row instance plus a
// 6-row instance sharing the same inputs for out-of-range addressing.
// Honours GOL_TORUS_EN for boundary expectations.
module tb_gol_board_state;
  import gol_pkg::*;

  localparam int R  = 8;
  localparam int RB = 3;
`ifdef GOL_TORUS_EN
  localparam bit TORUS = 1'b1;
`else
  localparam bit TORUS = 1'b0;
`endif

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #10 clk = ~clk;

  logic          load_en = 1'b0;
  logic [RB-1:0] load_addr = '0;
  logic [7:0]    load_data = '0;
  logic          we = 1'b0;
  logic [RB-1:0] wa = '0;
  logic [7:0]    wd = '0;
  logic          commit = 1'b0;
  logic [RB-1:0] ra = '0;

  logic [7:0]  rd_above, rd_cur, rd_below;
  logic        commit_ready, commit_ack, stable, all_dead;
  logic [15:0] gen_count;

  logic [7:0]  o6_rd_above, o6_rd_cur, o6_rd_below;
  logic        o6_commit_ready, o6_commit_ack, o6_stable, o6_all_dead;
  logic [15:0] o6_gen_count;

  gol_board_state #(.WIDTH(8), .ROWS(R), .REGBITS(RB), .GENBITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .we(we), .wa(wa), .wd(wd), .commit(commit), .ra(ra),
    .rd_above(rd_above), .rd_cur(rd_cur), .rd_below(rd_below),
    .commit_ready(commit_ready), .commit_ack(commit_ack), .gen_count(gen_count),
    .stable(stable), .all_dead(all_dead)
  );

  gol_board_state #(.WIDTH(8), .ROWS(6), .REGBITS(RB), .GENBITS(16)) dut6 (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .we(we), .wa(wa), .wd(wd), .commit(commit), .ra(ra),
    .rd_above(o6_rd_above), .rd_cur(o6_rd_cur), .rd_below(o6_rd_below),
    .commit_ready(o6_commit_ready), .commit_ack(o6_commit_ack), .gen_count(o6_gen_count),
    .stable(o6_stable), .all_dead(o6_all_dead)
  );

  // scoreboard
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  row_t        model_cur [R];
  logic [15:0] model_gen = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] got);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got %0h expected <scoreboard empty>", tag, got);
    end else begin
      chk(tag, got, exp_q.pop_front());
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_row(input int a, input logic [7:0] d);
    load_en = 1'b1; load_addr = RB'(a); load_data = d;
    tick();
    load_en = 1'b0;
    if (a < R) model_cur[a] = d;
    model_gen = '0;
  endtask

  task automatic write_row(input int a, input logic [7:0] d, input logic c);
    we = 1'b1; wa = RB'(a); wd = d; commit = c;
    tick();
    we = 1'b0; commit = 1'b0;
  endtask

  task automatic check_rows(input string tag);
    for (int i = 0; i < R; i++) begin
      ra = RB'(i);
      #1;
      chk(tag, rd_cur, model_cur[i]);
    end
  endtask

  // writes a full next generation, commits on the last write cycle
  task automatic full_gen(input row_t b [R]);
    logic same;
    same = 1'b1;
    for (int i = 0; i < R; i++) if (b[i] !== model_cur[i]) same = 1'b0;
    for (int i = 0; i < R - 1; i++) write_row(i, b[i], 1'b0);
    push_exp(32'd1);
    push_exp(32'(model_gen + 16'd1));
    push_exp(32'(same));
    write_row(R - 1, b[R-1], 1'b1);
    pop_chk("commit_ack", 32'(commit_ack));
    pop_chk("gen_count", 32'(gen_count));
    pop_chk("stable", 32'(stable));
    model_gen = model_gen + 16'd1;
    model_cur = b;
    check_rows("gen_rows");
  endtask

  row_t board [R];

  initial begin
    for (int i = 0; i < R; i++) model_cur[i] = '0;

    // reset state, checked while reset is held and before any clock edge
    #1 rst_n = 1'b0;
    #2;
    chk("rst_all_dead", 32'(all_dead), 32'd1);
    chk("rst_gen", 32'(gen_count), 32'd0);
    chk("rst_ready", 32'(commit_ready), 32'd0);
    chk("rst_ack", 32'(commit_ack), 32'd0);
    chk("rst_stable", 32'(stable), 32'd0);
    chk("rst_rd_cur", 32'(rd_cur), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // commit with nothing written is ignored
    commit = 1'b1;
    push_exp(32'd0);
    tick();
    commit = 1'b0;
    pop_chk("empty_commit_ack", 32'(commit_ack));
    chk("empty_commit_gen", 32'(gen_count), 32'd0);

    // seed a vertical blinker
    for (int i = 0; i < R; i++) load_row(i, (i >= 3 && i <= 5) ? 8'h08 : 8'h00);
    ra = 3'd4;
    #1;
    chk("blinker_above", 32'(rd_above), 32'h08);
    chk("blinker_cur", 32'(rd_cur), 32'h08);
    chk("blinker_below", 32'(rd_below), 32'h08);
    chk("blinker_alive", 32'(all_dead), 32'd0);

    // 7 of 8 rows written: commit must be refused
    for (int i = 0; i < R; i++) board[i] = '0;
    board[4] = 8'h1C;
    for (int i = 0; i < R - 1; i++) write_row(i, board[i], 1'b0);
    chk("partial_ready", 32'(commit_ready), 32'd0);
    commit = 1'b1;
    push_exp(32'd0);
    tick();
    commit = 1'b0;
    pop_chk("partial_commit_ack", 32'(commit_ack));
    chk("partial_commit_gen", 32'(gen_count), 32'd0);

    // last row together with commit
    push_exp(32'd1);
    push_exp(32'd1);
    push_exp(32'd0);
    write_row(R - 1, board[R-1], 1'b1);
    pop_chk("last_row_ack", 32'(commit_ack));
    pop_chk("last_row_gen", 32'(gen_count));
    pop_chk("last_row_stable", 32'(stable));
    model_gen = 16'd1;
    model_cur = board;
    ra = 3'd4;
    #1;
    chk("horiz_cur", 32'(rd_cur), 32'h1C);
    chk("horiz_above", 32'(rd_above), 32'h00);
    chk("post_commit_ready", 32'(commit_ready), 32'd0);
    tick();
    chk("ack_one_cycle", 32'(commit_ack), 32'd0);

    // identical board (row 2 first scribbled then restored) -> stable
    write_row(2, 8'hFF, 1'b0);
    full_gen(board);

    // single-bit change -> not stable
    board[4] = 8'h1D;
    full_gen(board);

    // boundary reads
    load_row(7, 8'hA5);
    load_row(0, 8'h3C);
    chk("load_gen_clear", 32'(gen_count), 32'd0);
    ra = 3'd0;
    #1;
    chk("bound_above", 32'(rd_above), TORUS ? 32'hA5 : 32'h00);
    chk("bound_cur0", 32'(rd_cur), 32'h3C);
    chk("r6_cur0", 32'(o6_rd_cur), 32'h3C);
    ra = 3'd7;
    #1;
    chk("bound_below", 32'(rd_below), TORUS ? 32'h3C : 32'h00);
    chk("bound_cur7", 32'(rd_cur), 32'hA5);
    ra = 3'd6;
    #1;
    chk("r6_oor_cur", 32'(o6_rd_cur), 32'h00);
    ra = 3'd5;
    #1;
    chk("r6_bound_below", 32'(o6_rd_below), TORUS ? 32'h3C : 32'h00);

    // load wins over a same-cycle commit
    for (int i = 0; i < R; i++) write_row(i, 8'(8'h11 * i), 1'b0);
    chk("full_ready", 32'(commit_ready), 32'd1);
    load_en = 1'b1; load_addr = 3'd1; load_data = 8'h77; commit = 1'b1;
    push_exp(32'd0);
    tick();
    load_en = 1'b0; commit = 1'b0;
    model_cur[1] = 8'h77;
    pop_chk("load_commit_ack", 32'(commit_ack));
    chk("load_commit_gen", 32'(gen_count), 32'd0);
    chk("load_commit_ready", 32'(commit_ready), 32'd0);
    ra = 3'd1;
    #1;
    chk("load_commit_rd", 32'(rd_cur), 32'h77);
    commit = 1'b1;
    push_exp(32'd0);
    tick();
    commit = 1'b0;
    pop_chk("after_load_commit_ack", 32'(commit_ack));

    // random generation, then asynchronous reset mid-generation
    model_gen = '0;
    for (int i = 0; i < R; i++) board[i] = 8'($urandom_range(1, 255));
    full_gen(board);
    for (int i = 0; i < 3; i++) write_row(i, 8'($urandom_range(0, 255)), 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("async_gen", 32'(gen_count), 32'd0);
    chk("async_all_dead", 32'(all_dead), 32'd1);
    chk("async_ready", 32'(commit_ready), 32'd0);
    chk("async_stable", 32'(stable), 32'd0);
    chk("async_ack", 32'(commit_ack), 32'd0);
    chk("async_rd_cur", 32'(rd_cur), 32'd0);
    chk("async_r6_dead", 32'(o6_all_dead), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d expected 0 entries left", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "timeout");
  end

endmodule
